// File: rtl/lighting_sequencer.sv
// Lighting-unit sequencer: walks a triangle buffer, issues one lighting
// request per triangle, collects the shaded colour and writes it out.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; latches batch length and light vector
// S_FETCH | tri_rd_en high with tri_addr = index
// S_LOAD  | tri_rdata valid, captured into lt_triangle / lt_input_rgb
// S_ISSUE | lt_en high for one cycle, watchdog reloaded
// S_WAIT  | waiting for a rising edge of lt_valid or watchdog expiry
// S_WRITE | out_wr_en high with the captured colour for this index
// S_DONE  | last cycle of busy; done pulses in the following cycle
//
// Outputs are registered on the transition into the state they belong to,
// so each strobe is high during its own state cycle. The watchdog is a
// down-counter loaded with TIMEOUT in ISSUE; hitting the terminal count of 1
// in WAIT means TIMEOUT WAIT cycles have elapsed without a result.
module lighting_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_tris,
  input  logic [47:0]       light_vec_in,
  output logic              tri_rd_en,
  output logic [ADDR_W-1:0] tri_addr,
  input  logic [167:0]      tri_rdata,
  output logic              lt_en,
  output logic [143:0]      lt_triangle,
  output logic [47:0]       lt_light_vec,
  output logic [23:0]       lt_input_rgb,
  input  logic              lt_valid,
  input  logic [23:0]       lt_output_rgb,
  input  logic              lt_illuminated,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_addr,
  output logic [23:0]       out_wdata,
  output logic [ADDR_W:0]   lit_count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [ADDR_W:0]   num_q;
  logic [ADDR_W-1:0] index;
  logic [WD_W-1:0]   wd;
  logic              lt_valid_q;
  logic              lt_rise;
  logic              last_tri;

  // A result counts only on a fresh edge, never on a level left over from
  // the previous request.
  assign lt_rise  = lt_valid & ~lt_valid_q;
  assign last_tri = ({1'b0, index} == (num_q - 1'b1));

  // Sequencer FSM with registered outputs and per-batch bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      num_q        <= '0;
      index        <= '0;
      wd           <= '0;
      lt_valid_q   <= 1'b0;
      tri_rd_en    <= 1'b0;
      tri_addr     <= '0;
      lt_en        <= 1'b0;
      lt_triangle  <= '0;
      lt_light_vec <= '0;
      lt_input_rgb <= '0;
      out_wr_en    <= 1'b0;
      out_addr     <= '0;
      out_wdata    <= '0;
      lit_count    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      lt_valid_q <= lt_valid;
      tri_rd_en  <= 1'b0;
      lt_en      <= 1'b0;
      out_wr_en  <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            num_q        <= num_tris;
            lt_light_vec <= light_vec_in;
            lit_count    <= '0;
            err          <= 1'b0;
            index        <= '0;
            busy         <= 1'b1;
            if (num_tris == '0) begin
              state <= S_DONE;
            end else begin
              tri_rd_en <= 1'b1;
              tri_addr  <= '0;
              state     <= S_FETCH;
            end
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          lt_triangle  <= tri_rdata[167:24];
          lt_input_rgb <= tri_rdata[23:0];
          lt_en        <= 1'b1;
          state        <= S_ISSUE;
        end
        S_ISSUE: begin
          wd    <= WD_W'(TIMEOUT);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (lt_rise) begin
            out_wr_en <= 1'b1;
            out_addr  <= index;
            out_wdata <= lt_output_rgb;
            if (lt_illuminated) lit_count <= lit_count + 1'b1;
            state     <= S_WRITE;
          end else if (wd <= WD_W'(1)) begin
            // Timed out: record black, count as not illuminated, move on.
            err       <= 1'b1;
            out_wr_en <= 1'b1;
            out_addr  <= index;
            out_wdata <= '0;
            state     <= S_WRITE;
          end else begin
            wd <= wd - 1'b1;
          end
        end
        S_WRITE: begin
          if (last_tri) begin
            state <= S_DONE;
          end else begin
            index     <= index + 1'b1;
            tri_rd_en <= 1'b1;
            tri_addr  <= index + 1'b1;
            state     <= S_FETCH;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lighting_sequencer.sv
// Self-checking bench for lighting_sequencer: table of batch vectors plus a
// hand-written reset-mid-batch sequence. Triangle memory and lighting stub
// are driven on the falling edge.
module tb_lighting_sequencer;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   num_tris;
  logic [47:0]       light_vec_in;
  logic              tri_rd_en;
  logic [ADDR_W-1:0] tri_addr;
  logic [167:0]      tri_rdata;
  logic              lt_en;
  logic [143:0]      lt_triangle;
  logic [47:0]       lt_light_vec;
  logic [23:0]       lt_input_rgb;
  logic              lt_valid;
  logic [23:0]       lt_output_rgb;
  logic              lt_illuminated;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_addr;
  logic [23:0]       out_wdata;
  logic [ADDR_W:0]   lit_count;
  logic              busy;
  logic              done;
  logic              err;

  lighting_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tris(num_tris),
    .light_vec_in(light_vec_in), .tri_rd_en(tri_rd_en), .tri_addr(tri_addr),
    .tri_rdata(tri_rdata), .lt_en(lt_en), .lt_triangle(lt_triangle),
    .lt_light_vec(lt_light_vec), .lt_input_rgb(lt_input_rgb),
    .lt_valid(lt_valid), .lt_output_rgb(lt_output_rgb),
    .lt_illuminated(lt_illuminated), .out_wr_en(out_wr_en),
    .out_addr(out_addr), .out_wdata(out_wdata), .lit_count(lit_count),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          num;
    int          mode;     // 0 pulse, 1 hold level high, 2 never valid
    int          delay;
    bit          extra;    // pulse start again while busy
    logic [47:0] light;
    bit          exp_err;
    int          exp_lit;
    int          exp_lat;  // falling edges from start sample to done
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [167:0] mem [0:255];
  logic [23:0]  res_rgb [0:3];
  logic         res_ill [0:3];
  logic [167:0] junk = {21{8'hee}};

  int          stub_mode = 0, stub_delay = 0, stub_req = 0, stub_cur = 0, stub_cnt = 0;
  bit          stub_armed = 0, rd_pend = 0;
  logic [7:0]  rd_addr_q = '0;
  logic [47:0] cur_light = '0;
  int          rd_cnt = 0, lten_cnt = 0, wr_cnt = 0, dn_cnt = 0;
  int          wr_addr [0:511];
  logic [23:0] wr_data [0:511];

  task automatic chk(input string nm, input logic [167:0] act, input logic [167:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Triangle memory (data one cycle after the strobe) and lighting stub.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_pend) tri_rdata = mem[rd_addr_q];
      else tri_rdata = junk;
      rd_pend   = tri_rd_en;
      rd_addr_q = tri_addr;
      if (stub_mode != 1) lt_valid = 1'b0;
      if (stub_armed) begin
        stub_cnt--;
        if (stub_mode == 1 && stub_cnt == 1) lt_valid = 1'b0;
        if (stub_cnt <= 0) begin
          stub_armed = 0;
          if (stub_mode != 2) begin
            lt_valid       = 1'b1;
            lt_output_rgb  = res_rgb[stub_cur % 4];
            lt_illuminated = res_ill[stub_cur % 4];
          end
        end
      end
      if (lt_en) begin
        stub_armed = 1;
        stub_cnt   = stub_delay;
        stub_cur   = stub_req;
        stub_req++;
      end
    end
  end

  // Output monitor: strobe counts, fetch address, request payload, writes.
  initial begin
    forever begin
      @(negedge clk);
      if (tri_rd_en) begin
        chk("tri_addr", tri_addr, rd_cnt);
        rd_cnt++;
      end
      if (lt_en) begin
        if (lten_cnt < 256) begin
          chk("lt_triangle", lt_triangle, mem[lten_cnt][167:24]);
          chk("lt_input_rgb", lt_input_rgb, mem[lten_cnt][23:0]);
        end
        chk("lt_light_vec", lt_light_vec, cur_light);
        lten_cnt++;
      end
      if (out_wr_en) begin
        if (wr_cnt < 512) begin
          wr_addr[wr_cnt] = int'(out_addr);
          wr_data[wr_cnt] = out_wdata;
        end
        wr_cnt++;
      end
      if (done) dn_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic prep(input int m, input int d, input logic [47:0] l);
    stub_mode  = m;
    stub_delay = d;
    stub_req   = 0;
    stub_armed = 0;
    cur_light  = l;
    rd_cnt     = 0;
    lten_cnt   = 0;
    wr_cnt     = 0;
    dn_cnt     = 0;
    if (m == 1) begin
      lt_valid       = 1'b1;
      lt_output_rgb  = 24'h123456;
      lt_illuminated = 1'b1;
    end
  endtask

  task automatic run_batch(input vec_t v);
    int k;
    logic [23:0] exp_d;
    prep(v.mode, v.delay, v.light);
    @(negedge clk);
    num_tris     = v.num[ADDR_W:0];
    light_vec_in = v.light;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    num_tris     = 9'd5;
    light_vec_in = 48'hdead_beef_0123;
    k = 1;
    chk("busy_after_start", busy, 1);
    chk("err_cleared_on_start", err, 0);
    chk("lit_cleared_on_start", lit_count, 0);
    if (v.extra) begin
      repeat (2) begin @(negedge clk); k++; end
      start = 1'b1;
      @(negedge clk);
      k++;
      start = 1'b0;
    end
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("done_latency", k, v.exp_lat);
    chk("busy_low_with_done", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("done_count", dn_cnt, 1);
    chk("rd_en_count", rd_cnt, v.num);
    chk("lt_en_count", lten_cnt, v.num);
    chk("write_count", wr_cnt, v.num);
    chk("lit_count", lit_count, v.exp_lit);
    chk("err", err, v.exp_err);
    chk("light_vec_held", lt_light_vec, v.light);
    for (int i = 0; i < wr_cnt && i < 512; i++) begin
      exp_d = (v.mode == 2) ? 24'h000000 : res_rgb[i % 4];
      chk("wr_addr", wr_addr[i], i);
      chk("wr_data", wr_data[i], exp_d);
    end
  endtask

  vec_t vecs [0:6];

  initial begin
    int k;
    mem[0] = {16'h4000, 16'h3c00, 16'h0000, 16'h0000, 16'h3c00, 16'h0000,
              16'h3c00, 16'h0000, 16'h0000, 24'hffffff};
    for (int i = 1; i < 256; i++)
      mem[i] = {{9{i[7:0], 8'ha5}}, i[7:0], 8'h5a, ~i[7:0]};
    res_rgb[0] = 24'hffffff; res_ill[0] = 1'b1;
    res_rgb[1] = 24'h000000; res_ill[1] = 1'b0;
    res_rgb[2] = 24'hd088d0; res_ill[2] = 1'b1;
    res_rgb[3] = 24'h00ff00; res_ill[3] = 1'b1;

    //          num mode dly extra light              err lit  lat
    vecs[0] = '{1,   0,  5,  1'b0, 48'h0000_0000_bc00, 1'b0, 1,   11};
    vecs[1] = '{3,   0,  3,  1'b1, 48'h1111_2222_3333, 1'b0, 2,   23};
    vecs[2] = '{3,   1,  4,  1'b0, 48'h4444_5555_6666, 1'b0, 2,   26};
    vecs[3] = '{1,   2,  0,  1'b0, 48'h7777_8888_9999, 1'b1, 0,   70};
    vecs[4] = '{2,   0,  1,  1'b0, 48'haaaa_bbbb_cccc, 1'b0, 1,   12};
    vecs[5] = '{256, 0,  1,  1'b0, 48'h3c00_0000_0000, 1'b0, 192, 1282};
    vecs[6] = '{0,   0,  1,  1'b0, 48'h0101_0202_0303, 1'b0, 0,   2};

    rst_n = 1'b0; start = 1'b0; num_tris = '0; light_vec_in = '0;
    lt_valid = 1'b0; lt_output_rgb = '0; lt_illuminated = 1'b0;
    tri_rdata = junk;
    repeat (2) @(negedge clk);
    chk("reset_strobes", {tri_rd_en, lt_en, out_wr_en, busy, done, err}, 0);
    chk("reset_addrs", {tri_addr, out_addr, lit_count}, 0);
    chk("reset_payload", {lt_triangle, lt_input_rgb}, 0);
    chk("reset_light_wdata", {lt_light_vec, out_wdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) run_batch(vecs[v]);

    // Reset while waiting on the second triangle of a 4-triangle batch.
    prep(0, 20, 48'h0a0a_0b0b_0c0c);
    @(negedge clk);
    num_tris = 9'd4; light_vec_in = 48'h0a0a_0b0b_0c0c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (lten_cnt < 2 && k < 200) begin @(negedge clk); k++; end
    chk("rst_test_second_request", lten_cnt, 2);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_wdata", out_wdata, 24'hffffff);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ctrl", {tri_rd_en, tri_addr, lt_en, out_wr_en, out_addr, lit_count, done, err}, 0);
    chk("midrst_wdata", out_wdata, 0);
    chk("midrst_triangle", lt_triangle, 0);
    chk("midrst_rgb_light", {lt_input_rgb, lt_light_vec}, 0);
    stub_armed = 0; rd_cnt = 0; lten_cnt = 0; wr_cnt = 0; dn_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("no_done_after_reset", dn_cnt, 0);
    chk("no_write_after_reset", wr_cnt, 0);
    chk("no_request_after_reset", lten_cnt, 0);
    run_batch('{2, 0, 2, 1'b0, 48'h5555_6666_7777, 1'b0, 1, 14});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lighting_sequencer.md
Name: lighting_sequencer

Overview:
- Initiator/driver for the lighting unit. Walks a triangle buffer, issues one triangle per lighting request, and collects the shaded colour. Writes each result to a colour output buffer.
- Sits between the triangle/colour source memory and the downstream framebuffer writer. Replaces the hand-driven en/valid sequencing used at unit level.

Parameters:
- ADDR_W, 8, width of triangle index / buffer address; max batch 2^ADDR_W triangles.
- TIMEOUT, 64, cycles allowed between lighting request and result before flagging error.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a batch (ignored unless idle).
- num_tris  in  ADDR_W+1  batch length, sampled on start; 0 means empty batch.
- light_vec_in  in  48  fp16 {x,y,z} light direction, sampled on start.
- tri_rd_en  out  1  triangle buffer read strobe.
- tri_addr  out  ADDR_W  triangle buffer read address.
- tri_rdata  in  168  {triangle[143:0], rgb[23:0]}, valid exactly 1 cycle after tri_rd_en.
- lt_en  out  1  one-cycle request pulse to lighting unit.
- lt_triangle  out  144  held stable from lt_en until the result is accepted.
- lt_light_vec  out  48  latched light vector.
- lt_input_rgb  out  24  held stable like lt_triangle.
- lt_valid  in  1  lighting result valid (may stay high across requests).
- lt_output_rgb  in  24  shaded colour.
- lt_illuminated  in  1  triangle faces light.
- out_wr_en  out  1  result write strobe.
- out_addr  out  ADDR_W  result address (= triangle index).
- out_wdata  out  24  shaded colour.
- lit_count  out  ADDR_W+1  illuminated triangles in current/last batch.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at batch end.
- err  out  1  sticky timeout flag; cleared by next accepted start or reset.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; index 0; watchdog 0.
  - Latched triangle/rgb/light_vec registers 0.
  - lt_valid edge register 0.
- FSM states: IDLE, FETCH, LOAD, ISSUE, WAIT, WRITE, DONE.
- IDLE:
  - On start, latch num_tris and light_vec_in; clear lit_count, err and index.
  - If num_tris=0, go to DONE; else go to FETCH.
- FETCH: assert tri_rd_en with tri_addr=index for 1 cycle; go to LOAD.
- LOAD: capture tri_rdata into lt_triangle/lt_input_rgb; go to ISSUE.
- ISSUE: lt_en=1 for exactly 1 cycle; clear watchdog; go to WAIT.
- WAIT:
  - Accept the result only on a rising edge of lt_valid (lt_valid=1 and previous-cycle lt_valid=0), seen at or after the cycle following lt_en.
  - Because edge detection is used, a level held high from the previous request is not accepted.
  - On acceptance, register lt_output_rgb and lt_illuminated; go to WRITE.
  - Watchdog increments each WAIT cycle. On reaching TIMEOUT: set err, write 24'h000000 for this index, treat the triangle as not illuminated, and continue to WRITE.
- WRITE:
  - out_wr_en=1 for 1 cycle with out_addr=index and out_wdata=captured rgb.
  - lit_count increments if illuminated.
  - If index = num_tris-1, go to DONE; else index+1 and go to FETCH.
- DONE: done=1 for 1 cycle; busy drops in the same cycle; go to IDLE.
- Latency per triangle: 4 cycles + lighting latency (rising edge to WRITE).
- start while busy: ignored; no effect on any counter.
- num_tris = 2^ADDR_W: full index range is used; index does not wrap before DONE.
- Reset mid-batch: immediate return to IDLE; no further write or done pulse.
- lt_triangle, lt_input_rgb and lt_light_vec hold their values after the batch until the next LOAD.

Test Plan:
- Single triangle {4000,3c00,0000 | 0000,3c00,0000 | 3c00,0000,0000}, rgb ffffff, light {0000,0000,bc00}, stub returns ffffff/illuminated after 5 cycles -> one lt_en pulse, one write addr 0 data ffffff, lit_count=1, done pulse, err=0.
- Batch of 3 with stub results (ffffff,1), (000000,0), (d088d0,1) -> writes to addr 0,1,2 with those colours in order; lit_count=2; exactly 3 lt_en pulses.
- Stub holds lt_valid high continuously between requests -> no result accepted without a new rising edge; writes still in order with no skipped index.
- Stub never asserts valid, TIMEOUT=64 -> err=1 after 64 WAIT cycles; write of 000000; batch completes; next start clears err.
- num_tris=0 -> done pulse 2 cycles after start; no tri_rd_en, lt_en or out_wr_en.
- rst_n low mid-WAIT of a 4-triangle batch -> all outputs 0 immediately; no done pulse; a new start runs cleanly from index 0.
